mul_pipe_hs: RTL and testbench
==============================

# mul_pipe_hs

Parametrised, pipelined multiplier with valid/ready handshaking on both sides, for datapaths that need more than a single-cycle combinational multiply. Operands can be signed or unsigned. Latency is configurable. The result is either truncated or saturated to the output width. The block sits between an operand-producing stage and a consumer that may apply backpressure, and replaces bare combinational multiply instances where timing or flow control demands it.

## Interface
- `din0_WIDTH`, default 8: operand A width (1..32).
- `din1_WIDTH`, default 8: operand B width (1..32).
- `dout_WIDTH`, default 8: result width (1..64).
- `NUM_STAGE`, default 2: pipeline latency in cycles (1..8).
- `SIGNED`, default 1: 1 = two's-complement operands, 0 = unsigned.
- `ap_clk`  in  1  clock; all logic is on the rising edge.
- `ap_rst_n`  in  1  reset; synchronous, active-low.
- `ce`  in  1  clock enable; when 0, all state holds.
- `in_valid`  in  1  operands are presented.
- `in_ready`  out  1  block accepts operands this cycle.
- `din0`  in  din0_WIDTH  operand A.
- `din1`  in  din1_WIDTH  operand B.
- `out_valid`  out  1  `dout` is valid.
- `out_ready`  in  1  consumer accepts `dout`.
- `dout`  out  dout_WIDTH  product.
- `sat_flag`  out  1  result was clipped. Present only with `MUL_SAT_EN`.

## Operation
- Input transfer occurs when `in_valid && in_ready && ce`. Output transfer occurs when `out_valid && out_ready && ce`.
- Pipeline stages form a shift register of {valid, data}.
- Stage 0 captures the full-width product, P_W = din0_WIDTH + din1_WIDTH bits, computed per `SIGNED`. Later stages carry P_W bits plus their valid bit.
- The final stage drives the width reduction combinationally into `dout`.
- Stall rule: `stall = out_valid && !out_ready`. When `stall` or `!ce`, every stage holds.
- Otherwise every stage advances, and stage 0 loads `in_valid`.
- `in_ready = !stall`. Bubbles are not compressed, so throughput is 1/cycle when unstalled.
- Width rule when dout_WIDTH >= P_W: `dout` is the product sign-extended (`SIGNED=1`) or zero-extended (`SIGNED=0`).
- Width rule when dout_WIDTH < P_W: `dout` is the low dout_WIDTH bits (wrap-around), unless `MUL_SAT_EN` is defined (see Configuration).
- Data in a stage whose valid bit is 0 is don't-care.
- Reset: all valid bits are cleared and all data registers are zeroed. Outputs after reset:
  - `out_valid` = 0
  - `in_ready` = 1
  - `dout` = 0
  - `sat_flag` = 0
- Reset mid-operation discards all in-flight products; none emerge afterwards.

## Timing
- An operand accepted at cycle edge N appears on `dout` with `out_valid=1` after edge N+NUM_STAGE, provided there were no stalls and `ce` stayed high.
- Each stall cycle or `ce=0` cycle adds one cycle of latency.
- `dout` and `out_valid` are held stable while `out_valid && !out_ready`.
- `in_ready` depends combinationally on `out_ready` only, never on `in_valid`.
- Back-to-back acceptance is allowed on every unstalled cycle.
- Simultaneous output transfer and input acceptance in the same cycle is legal. It causes no loss and no duplication.

## Configuration
- `MUL_SAT_EN` defined: when dout_WIDTH < P_W, the result clamps.
  - `SIGNED=1`: clamp to [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1].
  - `SIGNED=0`: clamp to [0, 2^dout_WIDTH-1].
  - `sat_flag` is registered alongside `dout` and is 1 exactly when clamping occurred.
  - The clamp comparison is performed in the last stage.
- `MUL_SAT_EN` undefined: wrap-around truncation, no `sat_flag` port, no comparator logic.

## Structure
- Shared package `mul_pipe_pkg` holds:
  - the `MAX_STAGE=8` constant;
  - the stage record typedef {valid, product};
  - a function computing P_W.
- One sub-module, `mul_pipe_reduce`, holds the combinational width reduction: extension, truncation, and the `MUL_SAT_EN` clamp. It is instantiated after the final stage.

## Test plan
- **Signed basic.** Defaults; din0=3, din1=-5. Expect `dout`=0xF1 (-15) with `out_valid` exactly 2 cycles after acceptance.
- **Wrap vs saturate.** Defaults; din0=-128, din1=-128.
  - Without `MUL_SAT_EN`: `dout`=0x00.
  - With `MUL_SAT_EN`: `dout`=0x7F and `sat_flag`=1.
  - Also din0=-128, din1=1: `dout`=0x80, `sat_flag`=0.
- **Unsigned, wide out.** SIGNED=0, dout_WIDTH=16; din0=255, din1=255. Expect `dout`=0xFE01.
- **Backpressure.** Stream 6 operand pairs {i, i+1}, holding `out_ready`=0 for 3 cycles mid-stream. Expect:
  - all 6 products emerge in order, none lost or duplicated;
  - `dout` stable during the stall;
  - `in_ready`=0 for exactly those 3 cycles.
- **Clock enable.** Drop `ce` for 2 cycles while a product is in flight. Expect latency to extend by 2 and the value to be correct.
- **Mid-op reset.** Accept 2 pairs, then assert `ap_rst_n`=0 for 1 cycle. Expect `out_valid`=0 and `dout`=0 afterwards, no stale outputs, and `in_ready`=1 on the first cycle after release.

Source files
------------

// File: rtl/mul_pipe_pkg.sv
// Shared constants, stage record and width helper for the pipelined handshake multiplier.
// Used by mul_pipe_hs and mul_pipe_reduce; the MUL_SAT_EN macro selects clamping in the reducer.
package mul_pipe_pkg;

  localparam int unsigned MAX_STAGE = 8;
  localparam int unsigned MAX_P_W   = 64;

  typedef struct packed {
    logic               valid;
    logic [MAX_P_W-1:0] product;
  } stage_t;

  function automatic int unsigned prod_width(input int unsigned a_w, input int unsigned b_w);
    return a_w + b_w;
  endfunction

endpackage

// File: rtl/mul_pipe_reduce.sv
// Combinational reduction of the full-width product to the output width.
// Extends when the output is wider; truncates, or clamps when MUL_SAT_EN is defined.
module mul_pipe_reduce #(
  parameter int unsigned P_W    = 16,
  parameter int unsigned DOUT_W = 8,
  parameter int unsigned SIGNED = 1
) (
  input  logic [P_W-1:0]    i_prod,
  output logic [DOUT_W-1:0] o_dout
`ifdef MUL_SAT_EN
  ,
  output logic              o_sat
`endif
);

  if (DOUT_W >= P_W) begin : g_ext
    if (SIGNED != 0) begin : g_sext
      assign o_dout = DOUT_W'($signed(i_prod));
    end else begin : g_zext
      assign o_dout = DOUT_W'(i_prod);
    end
`ifdef MUL_SAT_EN
    assign o_sat = 1'b0;
`endif
  end else begin : g_trunc
`ifdef MUL_SAT_EN
    logic              w_ovf;
    logic [DOUT_W-1:0] w_clamp;
    logic [DOUT_W-1:0] w_min;

    if (SIGNED != 0) begin : g_sclamp
      // In range only when all bits from the result sign upward agree.
      assign w_ovf   = !((&i_prod[P_W-1:DOUT_W-1]) || !(|i_prod[P_W-1:DOUT_W-1]));
      assign w_min   = DOUT_W'(1) << (DOUT_W - 1);
      assign w_clamp = i_prod[P_W-1] ? w_min : ~w_min;
    end else begin : g_uclamp
      assign w_ovf   = |i_prod[P_W-1:DOUT_W];
      assign w_min   = '0;
      assign w_clamp = '1;
    end

    assign o_dout = w_ovf ? w_clamp : i_prod[DOUT_W-1:0];
    assign o_sat  = w_ovf;
`else
    logic w_unused_hi;

    assign o_dout      = i_prod[DOUT_W-1:0];
    assign w_unused_hi = ^i_prod[P_W-1:DOUT_W];
`endif
  end

endmodule

// File: rtl/mul_pipe_hs.sv
// Pipelined multiplier with valid/ready handshake on both sides and configurable latency.
// Define MUL_SAT_EN to clamp narrow results and expose sat_flag.
module mul_pipe_hs
  import mul_pipe_pkg::*;
#(
  parameter int unsigned din0_WIDTH = 8,
  parameter int unsigned din1_WIDTH = 8,
  parameter int unsigned dout_WIDTH = 8,
  parameter int unsigned NUM_STAGE  = 2,
  parameter int unsigned SIGNED     = 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout
`ifdef MUL_SAT_EN
  ,
  output logic                  sat_flag
`endif
);

  localparam int unsigned P_W   = prod_width(din0_WIDTH, din1_WIDTH);
  localparam int unsigned N_STG = (NUM_STAGE < 1) ? 1 :
                                  ((NUM_STAGE > MAX_STAGE) ? MAX_STAGE : NUM_STAGE);
  localparam int unsigned LAST  = N_STG - 1;

  logic [P_W-1:0]     w_a;
  logic [P_W-1:0]     w_b;
  logic [P_W-1:0]     w_prod;
  logic               w_stall;
  logic               w_adv;
  stage_t             w_in;
  stage_t [LAST:0]    w_next;
  stage_t [LAST:0]    r_stage;

  // Low P_W bits of the extended operands' product are exact in both modes.
  if (SIGNED != 0) begin : g_sop
    assign w_a = P_W'($signed(din0));
    assign w_b = P_W'($signed(din1));
  end else begin : g_uop
    assign w_a = P_W'(din0);
    assign w_b = P_W'(din1);
  end

  assign w_prod  = w_a * w_b;
  assign w_in    = {in_valid, MAX_P_W'(w_prod)};

  assign w_stall   = r_stage[LAST].valid && !out_ready;
  assign w_adv     = ce && !w_stall;
  assign in_ready  = !w_stall;
  assign out_valid = r_stage[LAST].valid;

  if (N_STG == 1) begin : g_one
    assign w_next = w_in;
  end else begin : g_many
    assign w_next = {r_stage[LAST-1:0], w_in};
  end

  // Whole pipeline holds together on stall or clock-enable low.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_stage <= '0;
    end else if (w_adv) begin
      r_stage <= w_next;
    end
  end

  if (P_W < MAX_P_W) begin : g_pad
    logic w_unused_hi;
    assign w_unused_hi = ^r_stage[LAST].product[MAX_P_W-1:P_W];
  end

  mul_pipe_reduce #(
    .P_W    (P_W),
    .DOUT_W (dout_WIDTH),
    .SIGNED (SIGNED)
  ) u_reduce (
    .i_prod (r_stage[LAST].product[P_W-1:0]),
    .o_dout (dout)
`ifdef MUL_SAT_EN
    ,
    .o_sat  (sat_flag)
`endif
  );

endmodule

// File: tb/tb_mul_pipe_hs.sv
// Self-checking bench for mul_pipe_hs: directed scenarios plus a randomized scoreboard run.
// Builds with or without MUL_SAT_EN; expected values follow the selected mode.
module tb_mul_pipe_hs;

  localparam int unsigned U_STG = 3;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        ce;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  din0;
  logic [7:0]  din1;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  dout;
  logic        u_in_valid;
  logic        u_in_ready;
  logic [7:0]  u_din0;
  logic [7:0]  u_din1;
  logic        u_out_valid;
  logic        u_out_ready;
  logic [15:0] u_dout;
`ifdef MUL_SAT_EN
  logic        sat_flag;
  logic        u_sat_flag;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [8:0]  exp_q[$];

  always #5 ap_clk = ~ap_clk;

  mul_pipe_hs dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din0      (din0),
    .din1      (din1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout)
`ifdef MUL_SAT_EN
    ,
    .sat_flag  (sat_flag)
`endif
  );

  mul_pipe_hs #(
    .din0_WIDTH (8),
    .din1_WIDTH (8),
    .dout_WIDTH (16),
    .NUM_STAGE  (U_STG),
    .SIGNED     (0)
  ) dut_u (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .ce        (ce),
    .in_valid  (u_in_valid),
    .in_ready  (u_in_ready),
    .din0      (u_din0),
    .din1      (u_din1),
    .out_valid (u_out_valid),
    .out_ready (u_out_ready),
    .dout      (u_dout)
`ifdef MUL_SAT_EN
    ,
    .sat_flag  (u_sat_flag)
`endif
  );

  // Reference: exact signed product, then clamp or wrap to 8 bits; bit 8 is the clip flag.
  function automatic logic [8:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    longint p;
    logic   s;
    p = longint'($signed(a)) * longint'($signed(b));
    s = 1'b0;
`ifdef MUL_SAT_EN
    if (p > 127) begin
      p = 127;
      s = 1'b1;
    end else if (p < -128) begin
      p = -128;
      s = 1'b1;
    end
`endif
    return {s, 8'(p)};
  endfunction

  task automatic test_reset();
    ap_rst_n = 1'b0; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    din0 = '0; din1 = '0;
    u_in_valid = 1'b0; u_out_ready = 1'b1; u_din0 = '0; u_din1 = '0;
    repeat (2) @(negedge ap_clk);
    ap_rst_n  = 1'b1;
    out_ready = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %h want 00", dout); end
    n_cmp++; if (u_out_valid !== 1'b0 || u_dout !== 16'h0000 || u_in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_unsigned_dut: got v=%b d=%h r=%b want 0 0000 1", u_out_valid, u_dout, u_in_ready);
    end
`ifdef MUL_SAT_EN
    n_cmp++; if (sat_flag !== 1'b0 || u_sat_flag !== 1'b0) begin
      n_err++; $display("FAIL reset_sat_flag: got %b/%b want 0/0", sat_flag, u_sat_flag);
    end
`endif
    out_ready = 1'b1;
  endtask

  task automatic test_signed_basic();
    @(negedge ap_clk);
    in_valid = 1'b1; din0 = 8'd3; din1 = 8'hFB; out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge ap_clk);
      in_valid = 1'b0;
      #1;
      n_cmp++; if (out_valid !== (k == 2)) begin
        n_err++; $display("FAIL basic_latency_k%0d: got out_valid=%b want %b", k, out_valid, (k == 2));
      end
      if (k == 2) begin
        n_cmp++; if (dout !== 8'hF1) begin n_err++; $display("FAIL basic_dout: got %h want f1", dout); end
      end
    end
  endtask

  task automatic test_wrap_sat();
    logic [7:0] e0;
    logic [7:0] e1;
`ifdef MUL_SAT_EN
    e0 = 8'h7F;
`else
    e0 = 8'h00;
`endif
    e1 = 8'h80;
    @(negedge ap_clk);
    in_valid = 1'b1; din0 = 8'h80; din1 = 8'h80; out_ready = 1'b1;
    @(negedge ap_clk);
    din0 = 8'h80; din1 = 8'h01;
    @(negedge ap_clk);
    in_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || dout !== e0) begin
      n_err++; $display("FAIL wrap_min_sq: got v=%b d=%h want 1 %h", out_valid, dout, e0);
    end
`ifdef MUL_SAT_EN
    n_cmp++; if (sat_flag !== 1'b1) begin n_err++; $display("FAIL sat_flag_set: got %b want 1", sat_flag); end
`endif
    @(negedge ap_clk);
    #1;
    n_cmp++; if (out_valid !== 1'b1 || dout !== e1) begin
      n_err++; $display("FAIL wrap_min_x1: got v=%b d=%h want 1 %h", out_valid, dout, e1);
    end
`ifdef MUL_SAT_EN
    n_cmp++; if (sat_flag !== 1'b0) begin n_err++; $display("FAIL sat_flag_clear: got %b want 0", sat_flag); end
`endif
    @(negedge ap_clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL wrap_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_unsigned_wide();
    @(negedge ap_clk);
    u_in_valid = 1'b1; u_din0 = 8'd255; u_din1 = 8'd255; u_out_ready = 1'b1;
    for (int k = 1; k <= U_STG; k++) begin
      @(negedge ap_clk);
      u_in_valid = 1'b0;
      #1;
      n_cmp++; if (u_out_valid !== (k == U_STG)) begin
        n_err++; $display("FAIL unsigned_latency_k%0d: got %b want %b", k, u_out_valid, (k == U_STG));
      end
    end
    n_cmp++; if (u_dout !== 16'hFE01) begin n_err++; $display("FAIL unsigned_dout: got %h want fe01", u_dout); end
`ifdef MUL_SAT_EN
    n_cmp++; if (u_sat_flag !== 1'b0) begin n_err++; $display("FAIL unsigned_sat: got %b want 0", u_sat_flag); end
`endif
    @(negedge ap_clk);
  endtask

  task automatic test_backpressure();
    int         idx;
    int         got;
    logic       exp_rdy;
    logic [7:0] held;
    logic [8:0] e;
    idx = 0; got = 0; held = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge ap_clk);
      in_valid  = (idx < 6);
      din0      = 8'(idx);
      din1      = 8'(idx + 1);
      exp_rdy   = !(cyc >= 4 && cyc <= 6);
      out_ready = exp_rdy;
      #1;
      n_cmp++; if (in_ready !== exp_rdy) begin
        n_err++; $display("FAIL bp_in_ready_c%0d: got %b want %b", cyc, in_ready, exp_rdy);
      end
      if (cyc == 4) held = dout;
      if (cyc == 5 || cyc == 6) begin
        n_cmp++; if (out_valid !== 1'b1 || dout !== held) begin
          n_err++; $display("FAIL bp_hold_c%0d: got v=%b d=%h want 1 %h", cyc, out_valid, dout, held);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL bp_spurious: got %h want none", dout);
        end else begin
          e = exp_q.pop_front();
          if (dout !== e[7:0]) begin n_err++; $display("FAIL bp_data_%0d: got %h want %h", got, dout, e[7:0]); end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_mul(din0, din1));
        idx++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++; if (got != 6 || exp_q.size() != 0) begin
      n_err++; $display("FAIL bp_count: got %0d left %0d want 6 0", got, exp_q.size());
    end
    repeat (2) begin
      @(negedge ap_clk);
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_duplicate: got %b want 0", out_valid); end
    end
  endtask

  task automatic test_ce();
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] e;
    a = 8'($urandom); b = 8'($urandom);
    e = ref_mul(a, b);
    @(negedge ap_clk);
    ce = 1'b1; in_valid = 1'b1; din0 = a; din1 = b; out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge ap_clk);
      in_valid = 1'b0;
      ce = !(k == 1 || k == 2);
      #1;
      n_cmp++; if (out_valid !== (k == 4)) begin
        n_err++; $display("FAIL ce_latency_k%0d: got %b want %b", k, out_valid, (k == 4));
      end
      if (k == 4) begin
        n_cmp++; if (dout !== e[7:0]) begin n_err++; $display("FAIL ce_dout: got %h want %h", dout, e[7:0]); end
      end
    end
    ce = 1'b1;
  endtask

  task automatic test_random();
    logic       p_valid;
    logic       p_hold;
    logic [7:0] p_dout;
    logic [8:0] e;
    int         drain;
    exp_q.delete();
    p_valid = 1'b0; p_hold = 1'b0; p_dout = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge ap_clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      ce        = ($urandom_range(0, 7) != 0);
      din0      = 8'($urandom);
      din1      = 8'($urandom);
      #1;
      if (p_hold) begin
        n_cmp++; if (out_valid !== 1'b1 || dout !== p_dout) begin
          n_err++; $display("FAIL rand_hold_c%0d: got v=%b d=%h want 1 %h", cyc, out_valid, dout, p_dout);
        end
      end
      n_cmp++; if (in_ready !== !(out_valid && !out_ready)) begin
        n_err++; $display("FAIL rand_in_ready_c%0d: got %b want %b", cyc, in_ready, !(out_valid && !out_ready));
      end
      n_cmp++; if (out_valid !== (exp_q.size() != 0 && p_valid) && out_valid === 1'b1 && exp_q.size() == 0) begin
        n_err++; $display("FAIL rand_phantom_c%0d: got out_valid=%b want 0", cyc, out_valid);
      end
      if (out_valid && out_ready && ce) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rand_spurious_c%0d: got %h want none", cyc, dout);
        end else begin
          e = exp_q.pop_front();
          if (dout !== e[7:0]) begin n_err++; $display("FAIL rand_data_c%0d: got %h want %h", cyc, dout, e[7:0]); end
`ifdef MUL_SAT_EN
          else if (sat_flag !== e[8]) begin n_err++; $display("FAIL rand_sat_c%0d: got %b want %b", cyc, sat_flag, e[8]); end
`endif
        end
      end
      if (in_valid && in_ready && ce) exp_q.push_back(ref_mul(din0, din1));
      p_valid = out_valid;
      p_hold  = out_valid && !(out_ready && ce);
      p_dout  = dout;
    end
    drain = 0;
    while (exp_q.size() != 0 && drain < 30) begin
      @(negedge ap_clk);
      in_valid = 1'b0; out_ready = 1'b1; ce = 1'b1;
      #1;
      if (out_valid) begin
        e = exp_q.pop_front();
        n_cmp++; if (dout !== e[7:0]) begin n_err++; $display("FAIL rand_drain_data: got %h want %h", dout, e[7:0]); end
      end
      drain++;
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rand_drain: got %0d pending want 0", exp_q.size()); end
    @(negedge ap_clk);
    in_valid = 1'b0; out_ready = 1'b1; ce = 1'b1;
  endtask

  task automatic test_midop_reset();
    @(negedge ap_clk);
    in_valid = 1'b1; din0 = 8'd7; din1 = 8'd9; out_ready = 1'b0;
    @(negedge ap_clk);
    din0 = 8'd5; din1 = 8'd6;
    @(negedge ap_clk);
    in_valid = 1'b0; ap_rst_n = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || dout !== 8'h00) begin
      n_err++; $display("FAIL rst_mid_out: got v=%b d=%h want 0 00", out_valid, dout);
    end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge ap_clk);
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_stale_k%0d: got %b want 0", k, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_signed_basic();
    test_wrap_sat();
    test_unsigned_wide();
    test_backpressure();
    test_ce();
    test_random();
    test_midop_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
